// File: rtl/zap_pkg.sv
// Shared types for the zap memory stage.
// Load-type decode and memory-stage FSM states.
package zap_pkg;

  typedef enum logic [0:0] {
    RUN,
    SLEEP
  } zap_mem_state_t;

  typedef enum logic [2:0] {
    LD_WORD,
    LD_UBYTE,
    LD_SBYTE,
    LD_UHALF,
    LD_SHALF
  } zap_ld_type_t;

  // Enables should be one-hot; overlaps resolve sbyte > ubyte > shalf > uhalf.
  function automatic zap_ld_type_t ld_type_f(
    input logic sb,
    input logic ub,
    input logic sh,
    input logic uh
  );
    zap_ld_type_t t;
    t = LD_WORD;
    if (sb)      t = LD_SBYTE;
    else if (ub) t = LD_UBYTE;
    else if (sh) t = LD_SHALF;
    else if (uh) t = LD_UHALF;
    return t;
  endfunction

endpackage

// File: rtl/zap_mem_load_align.sv
// Load data extraction and extension from a 32-bit D-cache word.
// Optional: ZAP_MEM_UNALIGNED_ROTATE_EN rotates unaligned word loads.
module zap_mem_load_align
  import zap_pkg::*;
(
  input  logic [31:0]  d,
  input  logic [1:0]   a,
  input  zap_ld_type_t ld_type,
  output logic [31:0]  data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Byte and halfword lanes selected by the low address bits.
  always_comb begin
    byte_v = d[{a, 3'b000} +: 8];
    half_v = d[{a[1], 4'b0000} +: 16];
  end

`ifdef ZAP_MEM_UNALIGNED_ROTATE_EN
  logic [4:0] rot;

  // ARMv4 LDR: unaligned word is rotated right by the byte offset.
  always_comb begin
    rot    = {a, 3'b000};
    word_v = (d >> rot) | (d << (6'd32 - {1'b0, rot}));
  end
`else
  // Word loads ignore the low address bits.
  always_comb begin
    word_v = d;
  end
`endif

  // Final extension by load type.
  always_comb begin
    data = word_v;
    unique case (ld_type)
      LD_UBYTE: data = {24'h0, byte_v};
      LD_SBYTE: data = {{24{byte_v[7]}}, byte_v};
      LD_UHALF: data = {16'h0, half_v};
      LD_SHALF: data = {{16{half_v[15]}}, half_v};
      LD_WORD:  data = word_v;
      default:  data = word_v;
    endcase
  end

endmodule

// File: rtl/zap_memory_main.sv
// Memory (load-return) stage between post-ALU and writeback.
// Optional: ZAP_MEM_UNALIGNED_ROTATE_EN (rotated unaligned word loads).
module zap_memory_main
  import zap_pkg::*;
#(
  parameter int unsigned PHY_REGS = 32'd46,
  parameter int unsigned FLAG_WDT = 32'd32,
  localparam int unsigned IW = $clog2(PHY_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear_from_writeback,
  input  logic                i_data_stall,
  input  logic                i_data_mem_fault,
  input  logic [31:0]         i_mem_rd_data,
  input  logic                i_uop_last,
  input  logic [511:0]        i_decompile,
  input  logic                i_decompile_valid,
  input  logic [31:0]         i_alu_result_ff,
  input  logic [31:0]         i_pc_plus_8_ff,
  input  logic [31:0]         i_mem_address_ff,
  input  logic                i_dav_ff,
  input  logic                i_abt_ff,
  input  logic                i_irq_ff,
  input  logic                i_fiq_ff,
  input  logic                i_swi_ff,
  input  logic                i_und_ff,
  input  logic [FLAG_WDT-1:0] i_flags_ff,
  input  logic [IW-1:0]       i_destination_index_ff,
  input  logic [IW-1:0]       i_mem_srcdest_index_ff,
  input  logic                i_mem_load_ff,
  input  logic                i_mem_unsigned_byte_enable_ff,
  input  logic                i_mem_signed_byte_enable_ff,
  input  logic                i_mem_unsigned_halfword_enable_ff,
  input  logic                i_mem_signed_halfword_enable_ff,
  output logic                o_uop_last,
  output logic [511:0]        o_decompile,
  output logic                o_decompile_valid,
  output logic [31:0]         o_alu_result_ff,
  output logic [31:0]         o_pc_plus_8_ff,
  output logic                o_dav_ff,
  output logic                o_abt_ff,
  output logic                o_irq_ff,
  output logic                o_fiq_ff,
  output logic                o_swi_ff,
  output logic                o_und_ff,
  output logic [FLAG_WDT-1:0] o_flags_ff,
  output logic [IW-1:0]       o_destination_index_ff,
  output logic [IW-1:0]       o_mem_srcdest_index_ff,
  output logic                o_mem_load_ff,
  output logic [31:0]         o_mem_rd_data_ff,
  output logic                o_mem_fault_ff,
  output logic                o_sleep
);

  zap_mem_state_t state;
  zap_mem_state_t state_nxt;
  zap_ld_type_t   ld_type;
  logic [31:0]    aligned;
  logic           unused_addr;

  assign unused_addr = ^i_mem_address_ff[31:2];
  assign o_sleep     = (state == SLEEP);

  assign ld_type = ld_type_f(
    i_mem_signed_byte_enable_ff,
    i_mem_unsigned_byte_enable_ff,
    i_mem_signed_halfword_enable_ff,
    i_mem_unsigned_halfword_enable_ff
  );

  zap_mem_load_align u_align (
    .d       (i_mem_rd_data),
    .a       (i_mem_address_ff[1:0]),
    .ld_type (ld_type),
    .data    (aligned)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= RUN;
    else         state <= state_nxt;
  end

  // Next state: a fault sleeps the stage until writeback clears it.
  always_comb begin
    state_nxt = state;
    if (i_clear_from_writeback)
      state_nxt = RUN;
    else if (!i_data_stall && state == RUN && i_data_mem_fault)
      state_nxt = SLEEP;
  end

  // Payload pipeline register: reset > clear > stall > run/sleep.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_uop_last             <= 1'b0;
      o_decompile            <= '0;
      o_decompile_valid      <= 1'b0;
      o_alu_result_ff        <= '0;
      o_pc_plus_8_ff         <= '0;
      o_dav_ff               <= 1'b0;
      o_abt_ff               <= 1'b0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_swi_ff               <= 1'b0;
      o_und_ff               <= 1'b0;
      o_flags_ff             <= '0;
      o_destination_index_ff <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_rd_data_ff       <= '0;
      o_mem_fault_ff         <= 1'b0;
    end else if (i_clear_from_writeback) begin
      o_uop_last        <= 1'b0;
      o_decompile_valid <= 1'b0;
      o_dav_ff          <= 1'b0;
      o_abt_ff          <= 1'b0;
      o_irq_ff          <= 1'b0;
      o_fiq_ff          <= 1'b0;
      o_swi_ff          <= 1'b0;
      o_und_ff          <= 1'b0;
      o_flags_ff        <= '0;
      o_mem_load_ff     <= 1'b0;
      o_mem_rd_data_ff  <= '0;
      o_mem_fault_ff    <= 1'b0;
    end else if (!i_data_stall) begin
      if (state == RUN) begin
        o_uop_last             <= i_uop_last;
        o_decompile            <= i_decompile;
        o_decompile_valid      <= i_decompile_valid;
        o_alu_result_ff        <= i_alu_result_ff;
        o_pc_plus_8_ff         <= i_pc_plus_8_ff;
        o_flags_ff             <= i_flags_ff;
        o_destination_index_ff <= i_destination_index_ff;
        o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
        if (i_data_mem_fault) begin
          o_dav_ff         <= 1'b0;
          o_abt_ff         <= 1'b0;
          o_irq_ff         <= 1'b0;
          o_fiq_ff         <= 1'b0;
          o_swi_ff         <= 1'b0;
          o_und_ff         <= 1'b0;
          o_mem_load_ff    <= 1'b0;
          o_mem_rd_data_ff <= '0;
          o_mem_fault_ff   <= 1'b1;
        end else begin
          o_dav_ff         <= i_dav_ff;
          o_abt_ff         <= i_abt_ff;
          o_irq_ff         <= i_irq_ff;
          o_fiq_ff         <= i_fiq_ff;
          o_swi_ff         <= i_swi_ff;
          o_und_ff         <= i_und_ff;
          o_mem_load_ff    <= i_mem_load_ff;
          o_mem_rd_data_ff <= i_mem_load_ff ? aligned : 32'h0;
          o_mem_fault_ff   <= 1'b0;
        end
      end else begin
        o_dav_ff         <= 1'b0;
        o_abt_ff         <= 1'b0;
        o_irq_ff         <= 1'b0;
        o_fiq_ff         <= 1'b0;
        o_swi_ff         <= 1'b0;
        o_und_ff         <= 1'b0;
        o_mem_load_ff    <= 1'b0;
        o_mem_rd_data_ff <= '0;
        o_mem_fault_ff   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zap_memory_main.sv
// Scoreboard bench for zap_memory_main.
// Expected results are queued at drive time and popped after the edge.
module tb_zap_memory_main;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_clear_from_writeback;
  logic         i_data_stall;
  logic         i_data_mem_fault;
  logic [31:0]  i_mem_rd_data;
  logic         i_uop_last;
  logic [511:0] i_decompile;
  logic         i_decompile_valid;
  logic [31:0]  i_alu_result_ff;
  logic [31:0]  i_pc_plus_8_ff;
  logic [31:0]  i_mem_address_ff;
  logic         i_dav_ff, i_abt_ff, i_irq_ff;
  logic         i_fiq_ff, i_swi_ff, i_und_ff;
  logic [31:0]  i_flags_ff;
  logic [5:0]   i_destination_index_ff;
  logic [5:0]   i_mem_srcdest_index_ff;
  logic         i_mem_load_ff;
  logic         i_ub, i_sb, i_uh, i_sh;
  logic         o_uop_last;
  logic [511:0] o_decompile;
  logic         o_decompile_valid;
  logic [31:0]  o_alu_result_ff;
  logic [31:0]  o_pc_plus_8_ff;
  logic         o_dav_ff, o_abt_ff, o_irq_ff;
  logic         o_fiq_ff, o_swi_ff, o_und_ff;
  logic [31:0]  o_flags_ff;
  logic [5:0]   o_destination_index_ff;
  logic [5:0]   o_mem_srcdest_index_ff;
  logic         o_mem_load_ff;
  logic [31:0]  o_mem_rd_data_ff;
  logic         o_mem_fault_ff;
  logic         o_sleep;

  always #5 clk = ~clk;

  zap_memory_main dut (
    .i_clk                             (clk),
    .i_reset                           (i_reset),
    .i_clear_from_writeback            (i_clear_from_writeback),
    .i_data_stall                      (i_data_stall),
    .i_data_mem_fault                  (i_data_mem_fault),
    .i_mem_rd_data                     (i_mem_rd_data),
    .i_uop_last                        (i_uop_last),
    .i_decompile                       (i_decompile),
    .i_decompile_valid                 (i_decompile_valid),
    .i_alu_result_ff                   (i_alu_result_ff),
    .i_pc_plus_8_ff                    (i_pc_plus_8_ff),
    .i_mem_address_ff                  (i_mem_address_ff),
    .i_dav_ff                          (i_dav_ff),
    .i_abt_ff                          (i_abt_ff),
    .i_irq_ff                          (i_irq_ff),
    .i_fiq_ff                          (i_fiq_ff),
    .i_swi_ff                          (i_swi_ff),
    .i_und_ff                          (i_und_ff),
    .i_flags_ff                        (i_flags_ff),
    .i_destination_index_ff            (i_destination_index_ff),
    .i_mem_srcdest_index_ff            (i_mem_srcdest_index_ff),
    .i_mem_load_ff                     (i_mem_load_ff),
    .i_mem_unsigned_byte_enable_ff     (i_ub),
    .i_mem_signed_byte_enable_ff       (i_sb),
    .i_mem_unsigned_halfword_enable_ff (i_uh),
    .i_mem_signed_halfword_enable_ff   (i_sh),
    .o_uop_last                        (o_uop_last),
    .o_decompile                       (o_decompile),
    .o_decompile_valid                 (o_decompile_valid),
    .o_alu_result_ff                   (o_alu_result_ff),
    .o_pc_plus_8_ff                    (o_pc_plus_8_ff),
    .o_dav_ff                          (o_dav_ff),
    .o_abt_ff                          (o_abt_ff),
    .o_irq_ff                          (o_irq_ff),
    .o_fiq_ff                          (o_fiq_ff),
    .o_swi_ff                          (o_swi_ff),
    .o_und_ff                          (o_und_ff),
    .o_flags_ff                        (o_flags_ff),
    .o_destination_index_ff            (o_destination_index_ff),
    .o_mem_srcdest_index_ff            (o_mem_srcdest_index_ff),
    .o_mem_load_ff                     (o_mem_load_ff),
    .o_mem_rd_data_ff                  (o_mem_rd_data_ff),
    .o_mem_fault_ff                    (o_mem_fault_ff),
    .o_sleep                           (o_sleep)
  );

  typedef struct {
    logic [31:0] rd;
    logic        dav;
    logic        fault;
    logic        load;
    logic        sleep;
    logic [31:0] alu;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        m_last;
  bit          m_sleep;
  logic [31:0] pc_ctr;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference alignment: en = {sbyte, ubyte, shalf, uhalf}.
  function automatic logic [31:0] ref_align(input logic [3:0] en,
                                            input logic [1:0] a,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    case (a)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    w = d;
`ifdef ZAP_MEM_UNALIGNED_ROTATE_EN
    case (a)
      2'd1: w = {d[7:0], d[31:8]};
      2'd2: w = {d[15:0], d[31:16]};
      2'd3: w = {d[23:0], d[31:24]};
      default: w = d;
    endcase
`endif
    if (en[3])      return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
    else if (en[2]) return {24'h0, b};
    else if (en[1]) return h[15] ? {16'hFFFF, h} : {16'h0, h};
    else if (en[0]) return {16'h0, h};
    return w;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    e = q.pop_front();
    check({tag, ".rd"},    o_mem_rd_data_ff, e.rd);
    check({tag, ".dav"},   {31'b0, o_dav_ff},       {31'b0, e.dav});
    check({tag, ".fault"}, {31'b0, o_mem_fault_ff}, {31'b0, e.fault});
    check({tag, ".load"},  {31'b0, o_mem_load_ff},  {31'b0, e.load});
    check({tag, ".sleep"}, {31'b0, o_sleep},        {31'b0, e.sleep});
    check({tag, ".alu"},   o_alu_result_ff, e.alu);
    check({tag, ".pc"},    o_pc_plus_8_ff,  e.pc);
  endtask

  task automatic step(input string tag,
                      input logic [3:0] en,
                      input logic [1:0] a,
                      input logic [31:0] d,
                      input logic ld,
                      input logic flt,
                      input logic clr,
                      input logic stl);
    exp_t e;
    i_sb = en[3];
    i_ub = en[2];
    i_sh = en[1];
    i_uh = en[0];
    i_mem_address_ff       = {30'h0000_4000, a};
    i_mem_rd_data          = d;
    i_mem_load_ff          = ld;
    i_data_mem_fault       = flt;
    i_clear_from_writeback = clr;
    i_data_stall           = stl;
    i_alu_result_ff        = ~d;
    i_pc_plus_8_ff         = pc_ctr;
    e = m_last;
    if (clr) begin
      e.dav = 0; e.fault = 0; e.load = 0;
      e.rd = 0; e.sleep = 0;
      m_sleep = 0;
    end else if (stl) begin
      e = m_last;
    end else if (m_sleep) begin
      e.dav = 0; e.fault = 0; e.load = 0;
      e.rd = 0; e.sleep = 1;
    end else begin
      e.alu = ~d;
      e.pc  = pc_ctr;
      if (flt) begin
        e.dav = 0; e.fault = 1; e.load = 0;
        e.rd = 0; e.sleep = 1;
        m_sleep = 1;
      end else begin
        e.dav = 1; e.fault = 0; e.load = ld;
        e.rd = ld ? ref_align(en, a, d) : 32'h0;
        e.sleep = 0;
      end
    end
    m_last = e;
    q.push_back(e);
    pc_ctr = pc_ctr + 32'd4;
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic do_reset(input string tag);
    i_reset      = 1'b1;
    i_data_stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_sleep = 0;
    m_last  = '{rd: 0, dav: 0, fault: 0, load: 0,
                sleep: 0, alu: 0, pc: 0};
    q.push_back(m_last);
    compare(tag);
    check({tag, ".flags"}, o_flags_ff, 32'h0);
    check({tag, ".dbg"},
          {30'b0, |o_decompile, o_decompile_valid}, 32'h0);
    i_reset      = 1'b0;
    i_data_stall = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pc_ctr   = 32'h100;
    i_reset = 1; i_clear_from_writeback = 0;
    i_data_stall = 0; i_data_mem_fault = 0;
    i_mem_rd_data = 0; i_uop_last = 1;
    i_decompile = {16{32'hDEC0DE00}};
    i_decompile_valid = 1;
    i_alu_result_ff = 0; i_pc_plus_8_ff = 0;
    i_mem_address_ff = 0;
    i_dav_ff = 1; i_abt_ff = 0; i_irq_ff = 0;
    i_fiq_ff = 0; i_swi_ff = 0; i_und_ff = 0;
    i_flags_ff = 32'hF000_0000;
    i_destination_index_ff = 6'd7;
    i_mem_srcdest_index_ff = 6'd9;
    i_mem_load_ff = 0;
    {i_sb, i_ub, i_sh, i_uh} = 4'b0;
    @(negedge clk);
    do_reset("reset");

    step("ubyte",  4'b0100, 2'd1, 32'hAABBCCDD, 1, 0, 0, 0);
    step("sbyte",  4'b1000, 2'd3, 32'h80112233, 1, 0, 0, 0);
    step("shalf",  4'b0010, 2'd2, 32'h80112233, 1, 0, 0, 0);
    step("uhalf",  4'b0001, 2'd0, 32'h80112233, 1, 0, 0, 0);
    step("word",   4'b0000, 2'd1, 32'h11223344, 1, 0, 0, 0);
    step("word0",  4'b0000, 2'd0, 32'hCAFEF00D, 1, 0, 0, 0);
    step("noload", 4'b0100, 2'd1, 32'hAABBCCDD, 0, 0, 0, 0);
    step("pri_sb", 4'b1111, 2'd0, 32'h000000F0, 1, 0, 0, 0);
    step("pri_ub", 4'b0110, 2'd0, 32'h0000F0F0, 1, 0, 0, 0);
    step("pri_sh", 4'b0011, 2'd0, 32'h00008001, 1, 0, 0, 0);

    step("pre_stl", 4'b0100, 2'd2, 32'h00550000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 4'b0001, 2'd2, 32'h9ABC0000, 1, 0, 0, 1);
    step("stl_rel", 4'b0001, 2'd2, 32'h9ABC0000, 1, 0, 0, 0);

    step("fault",   4'b0000, 2'd0, 32'h12345678, 1, 1, 0, 0);
    step("sleep1",  4'b0000, 2'd0, 32'h87654321, 1, 0, 0, 0);
    step("slp_flt", 4'b0000, 2'd0, 32'h0BADF00D, 1, 1, 0, 0);
    step("slp_stl", 4'b0000, 2'd0, 32'h0BADF00D, 1, 0, 0, 1);
    step("clear",   4'b0000, 2'd0, 32'h0BADF00D, 1, 0, 1, 0);
    step("post_clr", 4'b1000, 2'd1, 32'h0000FF00, 1, 0, 0, 0);

    step("clr_flt", 4'b0000, 2'd0, 32'h22222222, 1, 1, 1, 0);
    step("after",   4'b0010, 2'd0, 32'h00007FFF, 1, 0, 0, 0);

    step("fault2",  4'b0000, 2'd0, 32'h33333333, 1, 1, 0, 0);
    do_reset("rst_slp");
    step("post_rst", 4'b0100, 2'd3, 32'h5A000000, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
